// File: rtl/wifi_tx_interleaver_ctrl_if.sv
// Bit-serial handshake between the encoder/puncturer, this controller and the
// block interleaver. master = controller side, slave = upstream/interleaver side.
interface wifi_tx_interleaver_ctrl_if;
  logic up_valid;
  logic up_data;
  logic up_ready;
  logic il_enable;
  logic il_valid_in;
  logic il_data_in;
  logic il_finished;

  modport master (
    input  up_valid, up_data, il_finished,
    output up_ready, il_enable, il_valid_in, il_data_in
  );

  modport slave (
    output up_valid, up_data, il_finished,
    input  up_ready, il_enable, il_valid_in, il_data_in
  );
endinterface

// File: rtl/wifi_tx_interleaver_ctrl.sv
// Symbol sequencer feeding the block interleaver: loads NCBPS coded bits per
// OFDM symbol, zero-pads the final symbol, hands the interleaver its readout
// window and waits for it to finish before loading the next symbol.
module wifi_tx_interleaver_ctrl #(
  parameter int CNT_W   = 16,
  parameter int SYM_W   = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           rate_sel,
  input  logic [CNT_W-1:0]     num_bits,
  wifi_tx_interleaver_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [SYM_W-1:0]     sym_count,
  output logic                 err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [8:0]        ncbps_q, ncbps_d;
  logic [8:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  nbits_q, nbits_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              seen_low_q, seen_low_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic              dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              sym_last;
  logic              frame_last;

  function automatic logic [8:0] ncbps_of(input logic [1:0] r);
    case (r)
      2'd0:    return 9'd48;
      2'd1:    return 9'd96;
      2'd2:    return 9'd192;
      default: return 9'd288;
    endcase
  endfunction

  // Upstream is only ever stalled outside LOAD, so ready is a pure state decode.
  assign bus.up_ready = (state_q == LOAD);
  assign xfer         = bus.up_valid & (state_q == LOAD);
  assign sym_last     = (bit_cnt_q == ncbps_q - 9'd1);
  assign frame_last   = (total_q == nbits_q - CNT_ONE);

  assign bus.il_enable   = en_q;
  assign bus.il_valid_in = vld_q;
  assign bus.il_data_in  = dat_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sym_count       = sym_q;
  assign err             = err_q;

  // Next-state and next-output decode; interleaver strobes default low so any
  // cycle without a bit to write leaves the interleaver holding.
  always_comb begin
    state_d    = state_q;
    ncbps_d    = ncbps_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    total_d    = total_q;
    wdog_d     = wdog_q;
    seen_low_d = seen_low_q;
    sym_d      = sym_q;
    busy_d     = busy_q;
    err_d      = err_q;
    en_d       = 1'b0;
    vld_d      = 1'b0;
    dat_d      = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sym_d     = '0;
          err_d     = 1'b0;
          bit_cnt_d = '0;
          total_d   = '0;
          if (num_bits != '0) begin
            ncbps_d = ncbps_of(rate_sel);
            nbits_d = num_bits;
            busy_d  = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          en_d      = 1'b1;
          vld_d     = 1'b1;
          dat_d     = bus.up_data;
          bit_cnt_d = bit_cnt_q + 9'd1;
          total_d   = total_q + CNT_ONE;
          // A full symbol wins over end-of-frame: no pad needed in that case.
          if (sym_last) begin
            bit_cnt_d  = '0;
            wdog_d     = '0;
            seen_low_d = 1'b0;
            state_d    = DRAIN;
          end else if (frame_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        en_d      = 1'b1;
        vld_d     = 1'b1;
        bit_cnt_d = bit_cnt_q + 9'd1;
        if (sym_last) begin
          bit_cnt_d  = '0;
          wdog_d     = '0;
          seen_low_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        // Enable high with no write strobe lets the interleaver read out.
        en_d   = 1'b1;
        wdog_d = wdog_q + WD_ONE;
        if (!bus.il_finished) seen_low_d = 1'b1;
        // Only a low-then-high on il_finished marks a completed readout.
        if (seen_low_q && bus.il_finished) begin
          seen_low_d = 1'b0;
          sym_d      = sym_q + SYM_ONE;
          state_d    = (total_q == nbits_q) ? DONE : LOAD;
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ncbps_q    <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      total_q    <= '0;
      wdog_q     <= '0;
      seen_low_q <= 1'b0;
      sym_q      <= '0;
      en_q       <= 1'b0;
      vld_q      <= 1'b0;
      dat_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ncbps_q    <= ncbps_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      total_q    <= total_d;
      wdog_q     <= wdog_d;
      seen_low_q <= seen_low_d;
      sym_q      <= sym_d;
      en_q       <= en_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_wifi_tx_interleaver_ctrl.sv
// Bench for wifi_tx_interleaver_ctrl: table of frames, randomized frames checked
// against a frame-level model (data bits then zero pad up to whole symbols),
// plus hand sequences for zero-length frames, interleaver hang and mid-frame reset.
module tb_wifi_tx_interleaver_ctrl;
  localparam int CNT_W = 16;
  localparam int SYM_W = 12;
  localparam int TO    = 200;
  localparam int RD    = 6;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       rate_sel;
  logic [CNT_W-1:0] num_bits;
  logic             busy, done, err;
  logic [SYM_W-1:0] sym_count;

  wifi_tx_interleaver_ctrl_if ifc();

  wifi_tx_interleaver_ctrl #(.CNT_W(CNT_W), .SYM_W(SYM_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rate_sel(rate_sel),
    .num_bits(num_bits), .bus(ifc), .busy(busy), .done(done),
    .sym_count(sym_count), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // interleaver model state (written only by the model process)
  logic got[$];
  int   premature = 0;
  int   clr_ack = 0;
  int   wcnt = 0;
  int   rd_left = 0;
  int   rd_count = 0;
  // controls written only by the stimulus process
  int   clr_req = 0;
  int   rd_limit = 1000000;
  int   cur_ncbps = 48;
  logic sent[$];

  typedef struct {
    logic [1:0] rs;
    int n;
    int mode;
    int exp_syms;
    int exp_writes;
  } vec_t;
  vec_t tbl[6];

  function automatic int ncbps_of(input logic [1:0] r);
    case (r)
      2'd0: return 48;
      2'd1: return 96;
      2'd2: return 192;
      default: return 288;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " up_ready"},    ifc.up_ready, 0);
    chk({tag, " il_enable"},   ifc.il_enable, 0);
    chk({tag, " il_valid_in"}, ifc.il_valid_in, 0);
    chk({tag, " il_data_in"},  ifc.il_data_in, 0);
    chk({tag, " busy"},        busy, 0);
    chk({tag, " done"},        done, 0);
    chk({tag, " sym_count"},   sym_count, 0);
    chk({tag, " err"},         err, 0);
  endtask

  // Interleaver model: collects writes, reads out once a full symbol is held
  // and enable is high without a write; flags readout windows on partial symbols.
  initial begin
    ifc.il_finished = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset || clr_req != clr_ack) begin
        wcnt = 0; rd_left = 0; rd_count = 0;
        ifc.il_finished = 1'b1;
        clr_ack = clr_req;
      end else begin
        if (ifc.il_valid_in) begin
          got.push_back(ifc.il_data_in);
          wcnt++;
          if (!ifc.il_enable) premature++;
        end
        if (rd_left > 0) begin
          rd_left--;
          if (rd_left == 0) ifc.il_finished = 1'b1;
        end else if (ifc.il_enable && !ifc.il_valid_in) begin
          if (wcnt == cur_ncbps) begin
            if (rd_count < rd_limit) begin
              rd_count++; wcnt = 0; rd_left = RD;
              ifc.il_finished = 1'b0;
            end
          end else if (wcnt != 0) begin
            premature++;
          end
        end
      end
    end
  end

  // One frame; mode 0 = continuous valid, 1 = toggling, 2 = random.
  task automatic run_frame(input logic [1:0] rs, input int n, input int mode,
                           input int exp_syms, input int exp_writes, input string tag);
    int base, cyc, mism, prem0, wr;
    bit seen_done;
    clr_req++;
    cur_ncbps = ncbps_of(rs);
    sent.delete();
    @(negedge clk);
    base = got.size();
    prem0 = premature;
    rate_sel = rs; num_bits = CNT_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_rise"}, busy, 1);
    chk({tag, " err_clr"}, err, 0);
    seen_done = 0; cyc = 0;
    while (!seen_done && cyc < 6000) begin
      case (mode)
        0: ifc.up_valid = 1'b1;
        1: ifc.up_valid = (cyc % 2 == 0);
        default: ifc.up_valid = 1'($urandom_range(0, 1));
      endcase
      ifc.up_data = 1'($urandom_range(0, 1));
      if (ifc.up_valid && ifc.up_ready) sent.push_back(ifc.up_data);
      @(negedge clk);
      cyc++;
      if (done) seen_done = 1;
    end
    ifc.up_valid = 1'b0;
    wr = got.size() - base;
    mism = 0;
    for (int k = 0; k < wr; k++)
      if (got[base + k] !== ((k < sent.size()) ? sent[k] : 1'b0)) mism++;
    chk({tag, " done_seen"}, seen_done, 1);
    chk({tag, " sym_count"}, sym_count, exp_syms);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " writes"}, wr, exp_writes);
    chk({tag, " transfers"}, sent.size(), n);
    chk({tag, " stream_mismatch"}, mism, 0);
    chk({tag, " premature_readout"}, premature - prem0, 0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
  endtask

  logic [1:0] rs;
  int n, md, ncb, syms, cyc, last_wr, err_at, dn, base;

  initial begin
    reset = 1'b0; start = 1'b0; rate_sel = 2'd0; num_bits = '0;
    ifc.up_valid = 1'b0; ifc.up_data = 1'b0;

    tbl[0] = '{2'd0, 48,  0, 1, 48};
    tbl[1] = '{2'd0, 100, 0, 3, 144};
    tbl[2] = '{2'd1, 96,  1, 1, 96};
    tbl[3] = '{2'd2, 200, 2, 2, 384};
    tbl[4] = '{2'd3, 289, 0, 2, 576};
    tbl[5] = '{2'd3, 1,   1, 1, 288};

    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b1;

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].rs, tbl[i].n, tbl[i].mode, tbl[i].exp_syms,
                tbl[i].exp_writes, $sformatf("tbl%0d", i));

    // zero-length frame: done two cycles after start, nothing written
    clr_req++;
    @(negedge clk);
    base = got.size();
    rate_sel = 2'd0; num_bits = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero done_early", done, 0);
    chk("zero busy1", busy, 0);
    @(negedge clk);
    chk("zero done", done, 1);
    chk("zero sym_count", sym_count, 0);
    chk("zero busy2", busy, 0);
    @(negedge clk);
    chk("zero done_one_cycle", done, 0);
    chk("zero writes", got.size() - base, 0);

    // interleaver hangs after the first symbol
    clr_req++;
    rd_limit = 1;
    cur_ncbps = 48;
    @(negedge clk);
    rate_sel = 2'd0; num_bits = CNT_W'(100); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; last_wr = -1; err_at = -1; dn = 0;
    while (err_at < 0 && cyc < 3000) begin
      ifc.up_valid = 1'b1;
      ifc.up_data = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (ifc.il_valid_in) last_wr = cyc;
      if (done) dn++;
      if (err) err_at = cyc;
    end
    ifc.up_valid = 1'b0;
    chk("hang err", err, 1);
    chk("hang delay", err_at - last_wr, TO);
    chk("hang no_done", dn, 0);
    chk("hang busy", busy, 0);
    chk("hang sym_count", sym_count, 1);
    rd_limit = 1000000;
    run_frame(2'd0, 48, 0, 1, 48, "after_hang");

    // randomized frames against the frame-level model
    for (int i = 0; i < 8; i++) begin
      rs = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 500);
      md = $urandom_range(0, 2);
      ncb = ncbps_of(rs);
      syms = (n + ncb - 1) / ncb;
      run_frame(rs, n, md, syms, syms * ncb, $sformatf("rnd%0d", i));
    end

    // reset in the middle of loading a symbol
    clr_req++;
    cur_ncbps = 48;
    sent.delete();
    @(negedge clk);
    rate_sel = 2'd0; num_bits = CNT_W'(48); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sent.size() < 20 && cyc < 500) begin
      ifc.up_valid = 1'b1;
      ifc.up_data = 1'($urandom_range(0, 1));
      if (ifc.up_ready) sent.push_back(ifc.up_data);
      @(negedge clk);
      cyc++;
    end
    ifc.up_valid = 1'b0;
    chk("mid pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1 check_reset("mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_frame(2'd0, 48, 0, 1, 48, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
